// File: rtl/usb_rx_pkg.sv
// Shared receive-path types and constants for the USB bit unstuffer.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    UNS_IDLE,
    UNS_RUN,
    UNS_FLUSH,
    UNS_ERR
  } uns_state_t;

  localparam int USB_STUFF_LEN = 6;
  localparam int USB_MAX_BITS  = 90;

  // Width of a counter that must hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rc_unstuffer_if.sv
// Serial bit stream into and out of rc_unstuffer, with framing strobes and status.
interface rc_unstuffer_if #(
  parameter int MAX_BITS = usb_rx_pkg::USB_MAX_BITS
);
  localparam int CNT_W = usb_rx_pkg::cnt_width(MAX_BITS);

  // There is no backpressure: s_in is consumed on every clock while a packet is open,
  // and s_out carries a payload bit exactly in the cycles where out_valid is 1.
  logic                   s_in;
  logic                   start_unstuffer;
  logic                   end_unstuffer;
  logic                   abort;
  logic                   s_out;
  logic                   out_valid;
  logic                   start_rc_crc;
  logic                   end_rc_crc;
  logic                   stuff_error;
  logic [CNT_W-1:0]       bit_count;
  usb_rx_pkg::uns_state_t dbg_state;

  modport master (
    output s_in, start_unstuffer, end_unstuffer, abort,
    input  s_out, out_valid, start_rc_crc, end_rc_crc, stuff_error, bit_count, dbg_state
  );

  modport slave (
    input  s_in, start_unstuffer, end_unstuffer, abort,
    output s_out, out_valid, start_rc_crc, end_rc_crc, stuff_error, bit_count, dbg_state
  );

endinterface

// File: rtl/rc_unstuff_fsm.sv
// Packet framing FSM for rc_unstuffer: state register, framing strobes, bit-acceptance qualifiers.
// Define STUFF_ERR_ABORT_EN to park the packet in UNS_ERR after a stuff violation.
module rc_unstuff_fsm
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_unstuffer,
  input  logic       end_unstuffer,
  input  logic       abort,
  input  logic       violation,
  output logic       bit_take,
  output logic       restart,
  output uns_state_t state,
  output logic       start_rc_crc,
  output logic       end_rc_crc
);

  // A start in any state opens a new packet whose bit 0 rides on s_in in the same cycle.
  assign restart  = !abort && start_unstuffer;
  assign bit_take = restart || (!abort && (state == UNS_RUN) && !end_unstuffer);

`ifndef STUFF_ERR_ABORT_EN
  logic unused_violation;
  assign unused_violation = violation;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= UNS_IDLE;
      start_rc_crc <= 1'b0;
      end_rc_crc   <= 1'b0;
    end else begin
      start_rc_crc <= 1'b0;
      end_rc_crc   <= 1'b0;
      if (abort) begin
        state <= UNS_IDLE;
      end else if (start_unstuffer) begin
        state        <= UNS_RUN;
        start_rc_crc <= 1'b1;
        end_rc_crc   <= (state == UNS_RUN) || (state == UNS_ERR);
      end else begin
        case (state)
          UNS_IDLE: state <= UNS_IDLE;
          UNS_RUN: begin
            if (end_unstuffer) begin
              state      <= UNS_FLUSH;
              end_rc_crc <= 1'b1;
            end
`ifdef STUFF_ERR_ABORT_EN
            else if (violation) begin
              state <= UNS_ERR;
            end
`endif
          end
          UNS_FLUSH: state <= UNS_IDLE;
          UNS_ERR: begin
`ifdef STUFF_ERR_ABORT_EN
            if (end_unstuffer) begin
              state      <= UNS_FLUSH;
              end_rc_crc <= 1'b1;
            end
`else
            state <= UNS_IDLE;
`endif
          end
          default: state <= UNS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/rc_unstuffer.sv
// Receive bit unstuffer: drops the 0 following STUFF_LEN ones, frames the packet, flags violations.
// Define STUFF_ERR_ABORT_EN to stop emitting bits after a stuff violation until the packet ends.
module rc_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int MAX_BITS  = USB_MAX_BITS
) (
  input logic           clk,
  input logic           rst_n,
  rc_unstuffer_if.slave bus
);

  localparam int CNT_W  = cnt_width(MAX_BITS);
  localparam int ONES_W = cnt_width(STUFF_LEN);

  logic [ONES_W-1:0] ones_cnt;
  logic [CNT_W-1:0]  bit_count;
  logic              s_out_q;
  logic              out_valid_q;
  logic              stuff_error_q;

  logic              bit_take;
  logic              restart;
  logic              start_rc_crc;
  logic              end_rc_crc;
  uns_state_t        state;

  logic [ONES_W-1:0] ones_eff;
  logic [CNT_W-1:0]  bc_eff;
  logic              is_stuff;
  logic              overrun;
  logic              violation;
  logic              emit;

  rc_unstuff_fsm u_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_unstuffer (bus.start_unstuffer),
    .end_unstuffer   (bus.end_unstuffer),
    .abort           (bus.abort),
    .violation       (violation),
    .bit_take        (bit_take),
    .restart         (restart),
    .state           (state),
    .start_rc_crc    (start_rc_crc),
    .end_rc_crc      (end_rc_crc)
  );

  // On a start the counters are seen as already cleared, so bit 0 is judged fresh.
  always_comb begin
    ones_eff  = restart ? '0 : ones_cnt;
    bc_eff    = restart ? '0 : bit_count;
    is_stuff  = (ones_eff == ONES_W'(STUFF_LEN));
    overrun   = !is_stuff && (bc_eff == CNT_W'(MAX_BITS));
    violation = bit_take && ((is_stuff && bus.s_in) || overrun);
    emit      = bit_take && !is_stuff && !overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt      <= '0;
      bit_count     <= '0;
      s_out_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      s_out_q     <= emit ? bus.s_in : 1'b0;
      out_valid_q <= emit;
      if (bit_take) begin
        ones_cnt <= (is_stuff || !bus.s_in) ? '0 : ones_eff + ONES_W'(1);
      end
      if (emit) begin
        bit_count <= bc_eff + CNT_W'(1);
      end
      if (violation) begin
        stuff_error_q <= 1'b1;
      end else if (restart) begin
        stuff_error_q <= 1'b0;
      end
    end
  end

  assign bus.s_out        = s_out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.start_rc_crc = start_rc_crc;
  assign bus.end_rc_crc   = end_rc_crc;
  assign bus.stuff_error  = stuff_error_q;
  assign bus.bit_count    = bit_count;
  assign bus.dbg_state    = state;

endmodule
